// File: rtl/hilo_pkg.sv
// Shared op codes, controller states and decode helpers for the HI/LO front end.
package hilo_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] MULT    = 4'd1;
  localparam logic [3:0] MULTU   = 4'd2;
  localparam logic [3:0] DIV     = 4'd3;
  localparam logic [3:0] DIVU    = 4'd4;
  localparam logic [3:0] MTHI    = 4'd5;
  localparam logic [3:0] MTLO    = 4'd6;
  localparam logic [3:0] MFHI    = 4'd7;
  localparam logic [3:0] MFLO    = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  // Codes above MFLO carry no meaning and behave exactly like OP_NONE.
  function automatic logic [3:0] norm_op(input logic [3:0] op);
    return (op > MFLO) ? OP_NONE : op;
  endfunction

  function automatic logic is_md_op(input logic [3:0] op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/hilo_unit.sv
// Execute-stage front end for multdiv: owns HI/LO, sequences start/done,
// and stalls HI/LO-related ops while a multiply or divide is in flight.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no operation in flight; MT*/MF* served, MULT*/DIV* accepted
// ST_START | md_start asserted for this single cycle
// ST_BUSY  | waiting for md_done; result written to HI/LO on that edge
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             stall,
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbz,
  output logic             md_start,
  output logic             md_multdivb,
  output logic             md_signedop,
  output logic [WIDTH-1:0] md_x,
  output logic [WIDTH-1:0] md_y,
  input  logic [WIDTH-1:0] md_prodh,
  input  logic [WIDTH-1:0] md_prodl,
  input  logic             md_done,
  input  logic             md_dbz
);

  state_e           state_q, state_d;
  logic [3:0]       op_n;
  logic             accept;
  logic             md_op;
  logic             div_zero;
  logic             finish;
  logic [WIDTH-1:0] hi_q, lo_q, x_q, y_q;
  logic             multdivb_q, signedop_q, dbz_q;

  assign op_n     = norm_op(op);
  assign md_op    = is_md_op(op_n);
  assign accept   = op_valid && (state_q == ST_IDLE);
  assign stall    = op_valid && (state_q != ST_IDLE) && (op_n != OP_NONE);
  // md_done is a level that stays high after completion, so it only counts in BUSY.
  assign finish   = (state_q == ST_BUSY) && md_done;
  assign div_zero = !multdivb_q && md_dbz;

  assign mf_data     = (op_n == MFHI) ? hi_q : lo_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbz         = dbz_q;
  assign md_x        = x_q;
  assign md_y        = y_q;
  assign md_multdivb = multdivb_q;
  assign md_signedop = signedop_q;

  // Next-state and start strobe.
  always_comb begin
    state_d  = state_q;
    md_start = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (accept && md_op) state_d = ST_START;
      ST_START: begin
        md_start = 1'b1;
        state_d  = ST_BUSY;
      end
      ST_BUSY:  if (md_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // HI/LO: multdiv result on completion, MT* writes when idle (never both at once).
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (finish && !div_zero) begin
      hi_q <= md_prodh;
      lo_q <= md_prodl;
    end else if (accept && (op_n == MTHI)) begin
      hi_q <= rs_val;
    end else if (accept && (op_n == MTLO)) begin
      lo_q <= rs_val;
    end
  end

  // Operand latch held steady from START until the unit returns to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      multdivb_q <= 1'b0;
      signedop_q <= 1'b0;
    end else if (accept && md_op) begin
      x_q        <= rs_val;
      y_q        <= rt_val;
      multdivb_q <= (op_n == MULT) || (op_n == MULTU);
      signedop_q <= (op_n == MULT) || (op_n == DIV);
    end
  end

  // Divide-by-zero pulse in the cycle after completion.
  always_ff @(posedge clk) begin
    if (reset) dbz_q <= 1'b0;
    else       dbz_q <= finish && div_zero;
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit with a behavioural multdiv stand-in.
module tb_hilo_unit;
  import hilo_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         op_valid = 1'b0;
  logic [3:0]   op = OP_NONE;
  logic [W-1:0] rs_val = '0, rt_val = '0;
  logic         stall, dbz, md_start, md_multdivb, md_signedop;
  logic [W-1:0] mf_data, hi, lo, md_x, md_y;
  logic [W-1:0] md_prodh = '0, md_prodl = '0;
  logic         md_done = 1'b0, md_dbz = 1'b0;

  int tests = 0;
  int fails = 0;
  int md_lat = 3;
  int md_cnt = 0;
  logic [W-1:0] hi_m = '0, lo_m = '0;

  hilo_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .mf_data(mf_data),
    .hi(hi), .lo(lo), .dbz(dbz), .md_start(md_start),
    .md_multdivb(md_multdivb), .md_signedop(md_signedop),
    .md_x(md_x), .md_y(md_y), .md_prodh(md_prodh), .md_prodl(md_prodl),
    .md_done(md_done), .md_dbz(md_dbz)
  );

  always #5 clk = ~clk;

  // Architectural result {hi, lo} of a multiply/divide op (divisor assumed nonzero).
  function automatic logic [63:0] ref_md(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (o)
      MULT:    return 64'(sa * sb);
      MULTU:   return 64'(ua * ub);
      DIV:     return {32'(sa % sb), 32'(sa / sb)};
      default: return {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  // Behavioural multdiv: done clears on the start edge, rises md_lat edges later, then holds.
  always @(posedge clk) begin
    if (reset) begin
      md_done <= 1'b0;
      md_dbz  <= 1'b0;
      md_cnt  <= 0;
    end else if (md_start) begin
      md_done <= 1'b0;
      md_cnt  <= md_lat;
      md_dbz  <= !md_multdivb && (md_y == '0);
      if (!md_multdivb && (md_y == '0))
        {md_prodh, md_prodl} <= 64'hBAD0BAD0_DEADBEEF;
      else
        {md_prodh, md_prodl} <= ref_md(md_multdivb ? (md_signedop ? MULT : MULTU)
                                                   : (md_signedop ? DIV : DIVU), md_x, md_y);
    end else if (md_cnt > 0) begin
      md_cnt <= md_cnt - 1;
      if (md_cnt == 1) md_done <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mt(input logic [3:0] o, input logic [W-1:0] v);
    op_valid = 1'b1; op = o; rs_val = v; rt_val = $urandom;
    #1 chk("mt_stall", 64'(stall), 64'(0));
    @(posedge clk); #1;
    op_valid = 1'b0; op = OP_NONE;
    if (o == MTHI) hi_m = v; else lo_m = v;
    chk("mt_hi", 64'(hi), 64'(hi_m));
    chk("mt_lo", 64'(lo), 64'(lo_m));
  endtask

  task automatic mf(input logic [3:0] o);
    op_valid = 1'b1; op = o; rs_val = $urandom;
    #1 chk("mf_stall", 64'(stall), 64'(0));
    chk("mf_data", 64'(mf_data), 64'((o == MFHI) ? hi_m : lo_m));
    @(posedge clk); #1;
    op_valid = 1'b0; op = OP_NONE;
  endtask

  // Issues one multiply/divide and presents 'pend' on every cycle while it runs.
  // Returns in cycle N+1 (first idle cycle) with op_valid dropped.
  task automatic run_md(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int lat, input logic [3:0] pend);
    int   n, starts;
    logic seen, pend_st, exp_dbz;
    md_lat   = lat;
    pend_st  = (pend >= MULT) && (pend <= MFLO);
    exp_dbz  = ((o == DIV) || (o == DIVU)) && (b == '0);
    op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
    #1 chk("acc_stall", 64'(stall), 64'(0));
    @(posedge clk); #1;
    op_valid = (pend != OP_NONE); op = pend; rs_val = $urandom; rt_val = $urandom;
    #1;
    chk("start", 64'(md_start), 64'(1));
    chk("md_x", 64'(md_x), 64'(a));
    chk("md_y", 64'(md_y), 64'(b));
    chk("multdivb", 64'(md_multdivb), 64'((o == MULT) || (o == MULTU)));
    chk("signedop", 64'(md_signedop), 64'((o == MULT) || (o == DIV)));
    chk("start_stall", 64'(stall), 64'(pend_st));
    starts = 1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (md_start) starts++;
      chk("busy_stall", 64'(stall), 64'(pend_st));
      chk("busy_dbz", 64'(dbz), 64'(0));
      seen = md_done;
    end
    if (!seen) chk("md_done_timeout", 64'(0), 64'(1));
    chk("start_count", 64'(starts), 64'(1));
    chk("busy_x_stable", 64'(md_x), 64'(a));
    @(posedge clk); #1;
    if (!exp_dbz) {hi_m, lo_m} = ref_md(o, a, b);
    chk("res_hi", 64'(hi), 64'(hi_m));
    chk("res_lo", 64'(lo), 64'(lo_m));
    chk("dbz", 64'(dbz), 64'(exp_dbz));
    chk("idle_stall", 64'(stall), 64'(0));
    if (pend == MFHI || pend == MFLO)
      chk("mf_after_done", 64'(mf_data), 64'((pend == MFHI) ? hi_m : lo_m));
    op_valid = 1'b0; op = OP_NONE;
  endtask

  task automatic idle();
    op_valid = 1'b0; op = OP_NONE;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] o, pend;
    logic [W-1:0] a, b;

    repeat (2) @(posedge clk);
    #1;
    op_valid = 1'b1; op = MULT;
    #1;
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_start", 64'(md_start), 64'(0));
    chk("rst_dbz", 64'(dbz), 64'(0));
    chk("rst_x", 64'(md_x), 64'(0));
    chk("rst_y", 64'(md_y), 64'(0));
    chk("rst_stall", 64'(stall), 64'(0));
    op_valid = 1'b0; op = OP_NONE;
    reset = 1'b0;
    @(posedge clk); #1;

    run_md(MULT, 32'h7FFFFFFF, 32'h00000002, 3, OP_NONE);
    chk("mult1_hi", 64'(hi), 64'h0);
    chk("mult1_lo", 64'(lo), 64'hFFFFFFFE);
    run_md(MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, OP_NONE);
    chk("mult2_hi", 64'(hi), 64'h0);
    chk("mult2_lo", 64'(lo), 64'h1);
    run_md(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4, OP_NONE);
    chk("multu_hi", 64'(hi), 64'hFFFFFFFE);
    chk("multu_lo", 64'(lo), 64'h1);
    run_md(DIV, 32'hFFFFFFF9, 32'h00000002, 1, OP_NONE);
    chk("div_lo", 64'(lo), 64'hFFFFFFFD);
    chk("div_hi", 64'(hi), 64'hFFFFFFFF);
    run_md(DIVU, 32'h00000007, 32'h00000002, 5, OP_NONE);
    chk("divu_lo", 64'(lo), 64'h3);
    chk("divu_hi", 64'(hi), 64'h1);

    mt(MTHI, 32'h12345678);
    mt(MTLO, 32'h9ABCDEF0);
    run_md(DIVU, 32'h5, 32'h0, 4, OP_NONE);
    idle();
    chk("dbz_one_cycle", 64'(dbz), 64'(0));
    chk("dbz_hi", 64'(hi), 64'h12345678);
    chk("dbz_lo", 64'(lo), 64'h9ABCDEF0);
    mf(MFHI);
    chk("dbz_mfhi", 64'(mf_data), 64'(0) | 64'(hi_m));

    run_md(MULT, 32'h23456789, 32'hABCDEF01, 5, MFLO);
    run_md(MULT, 32'h00001234, 32'h00005678, 3, MULT);
    run_md(MULT, 32'h80000000, 32'h00000003, 2, MTHI);
    mf(MFLO);

    // Reset two cycles into BUSY.
    md_lat = 10;
    op_valid = 1'b1; op = MULT; rs_val = 32'h11111111; rt_val = 32'h22222222;
    @(posedge clk); #1;
    op_valid = 1'b0; op = OP_NONE;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    op_valid = 1'b1; op = MFLO;
    @(posedge clk); #1;
    reset = 1'b0;
    hi_m = '0; lo_m = '0;
    chk("mid_rst_hi", 64'(hi), 64'(0));
    chk("mid_rst_lo", 64'(lo), 64'(0));
    chk("mid_rst_stall", 64'(stall), 64'(0));
    chk("mid_rst_start", 64'(md_start), 64'(0));
    chk("mid_rst_mf", 64'(mf_data), 64'(0));
    op_valid = 1'b0; op = OP_NONE;
    @(posedge clk); #1;
    chk("post_rst_start", 64'(md_start), 64'(0));
    run_md(MULTU, 32'h2, 32'h3, 3, OP_NONE);
    chk("post_rst_lo", 64'(lo), 64'h6);

    for (int i = 0; i < 24; i++) begin
      o = 4'($urandom_range(1, 4));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      case ($urandom_range(0, 6))
        0: pend = OP_NONE;
        1: pend = MFHI;
        2: pend = MFLO;
        3: pend = MTHI;
        4: pend = MTLO;
        5: pend = 4'hC;
        default: pend = DIVU;
      endcase
      run_md(o, a, b, $urandom_range(1, 6), pend);
      if ($urandom_range(0, 1) == 1) mt(MTLO, $urandom);
      mf($urandom_range(0, 1) == 1 ? MFHI : MFLO);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
